// File: rtl/lsu_dcw_pkg.sv
// rtl/lsu_dcw_pkg.sv - shared types and write-entry formatting for the d-cache write controller
package lsu_dcw_pkg;

  localparam int WDATA_W = 144;
  localparam int PAR_LSB = 128;

  typedef struct packed {
    logic [7:0]   addr;
    logic [1:0]   way;
    logic [127:0] data;
    logic [15:0]  byte_en;
  } dcw_entry_t;

  // Fills write the whole 16B line (offset bit cleared); stores replicate the 8B
  // doubleword into both halves and steer the mask by the offset bit (addr[0]).
  function automatic dcw_entry_t dcw_format(input logic         fill,
                                            input logic [7:0]   addr,
                                            input logic [1:0]   way,
                                            input logic [127:0] data,
                                            input logic [7:0]   bmask);
    dcw_entry_t e;
    e.way = way;
    if (fill) begin
      e.addr    = {addr[7:1], 1'b0};
      e.data    = data;
      e.byte_en = 16'hFFFF;
    end else begin
      e.addr    = addr;
      e.data    = {data[63:0], data[63:0]};
      e.byte_en = addr[0] ? {bmask, 8'h00} : {8'h00, bmask};
    end
    return e;
  endfunction

endpackage

// File: rtl/lsu_dcw_par16.sv
// rtl/lsu_dcw_par16.sv - even parity for each of 16 data bytes
module lsu_dcw_par16 (
  input  logic [127:0] data,
  output logic [15:0]  par
);

  // One parity bit per byte, independent of which bytes are enabled.
  always_comb begin
    par = '0;
    for (int i = 0; i < 16; i++) begin
      par[i] = ^data[8*i +: 8];
    end
  end

endmodule

// File: rtl/lsu_dcw_ctl.sv
// rtl/lsu_dcw_ctl.sv - d-cache write buffer, load arbitration and alt-port write driver
module lsu_dcw_ctl
  import lsu_dcw_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                l2clk,
  input  logic                lsu_rst,
  input  logic                req_vld,
  output logic                req_rdy,
  input  logic                req_fill,
  input  logic [7:0]          req_addr,
  input  logic [1:0]          req_way,
  input  logic [127:0]        req_data,
  input  logic [7:0]          req_bmask,
  input  logic                ld_req_d,
  output logic                ld_stall_d,
  output logic [7:0]          dcache_alt_addr_e,
  output logic                dcache_alt_addr_sel_e,
  output logic                dcache_wvld_e,
  output logic                dcache_wclk_en_e,
  output logic                dcache_clk_en_e,
  output logic [WDATA_W-1:0]  dcache_wdata_e,
  output logic [1:0]          dcache_wr_way_e,
  output logic [15:0]         dcache_byte_wr_en_e,
  output logic                dcw_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  dcw_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [SC_W-1:0]  starve_cnt;

  logic             head_vld, starved, push, pop;
  logic             wvld_q, ld_req_q;
  dcw_entry_t       head;
  logic [15:0]      head_par;

  assign head_vld   = (count != '0);
  assign starved    = (starve_cnt == SC_W'(STARVE_MAX));
  assign req_rdy    = (count < CNT_W'(DEPTH));
  assign push       = req_vld & req_rdy;
  assign pop        = head_vld & (~ld_req_d | starved);
  assign ld_stall_d = head_vld & ld_req_d & starved;
  assign head       = mem[rd_ptr];

  lsu_dcw_par16 u_par (
    .data (head.data),
    .par  (head_par)
  );

  // Buffer storage; entries are formatted on the way in so the drain path is a plain copy.
  always_ff @(posedge l2clk) begin
    if (push) begin
      mem[wr_ptr] <= dcw_format(req_fill, req_addr, req_way, req_data, req_bmask);
    end
  end

  // Pointers and occupancy; in-order drain keeps fill-before-store ordering.
  always_ff @(posedge l2clk) begin
    if (lsu_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Count consecutive cycles the head write loses to a load, saturating at the force point.
  always_ff @(posedge l2clk) begin
    if (lsu_rst || pop || !head_vld) begin
      starve_cnt <= '0;
    end else if (ld_req_d && !starved) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

  // E-stage write port registers; data/addr/way/byte enables hold between writes.
  always_ff @(posedge l2clk) begin
    if (lsu_rst) begin
      wvld_q              <= 1'b0;
      ld_req_q            <= 1'b0;
      dcache_alt_addr_e   <= '0;
      dcache_wr_way_e     <= '0;
      dcache_wdata_e      <= '0;
      dcache_byte_wr_en_e <= '0;
    end else begin
      wvld_q   <= pop;
      ld_req_q <= ld_req_d & ~ld_stall_d;
      if (pop) begin
        dcache_alt_addr_e   <= head.addr;
        dcache_wr_way_e     <= head.way;
        dcache_wdata_e      <= {head_par, head.data};
        dcache_byte_wr_en_e <= head.byte_en;
      end
    end
  end

  assign dcache_wvld_e         = wvld_q;
  assign dcache_alt_addr_sel_e = wvld_q;
  assign dcache_wclk_en_e      = wvld_q;
  assign dcache_clk_en_e       = wvld_q | ld_req_q;
  assign dcw_empty             = (count == '0) & ~wvld_q;

endmodule

// File: tb/tb_lsu_dcw_ctl.sv
// tb/tb_lsu_dcw_ctl.sv - randomized and directed self-checking bench for lsu_dcw_ctl
module tb_lsu_dcw_ctl;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  typedef struct {
    logic [7:0]   addr;
    logic [1:0]   way;
    logic [127:0] data;
    logic [15:0]  be;
  } ent_t;

  logic         l2clk = 1'b0;
  logic         lsu_rst = 1'b1;
  logic         req_vld = 1'b0, req_fill = 1'b0, ld_req_d = 1'b0;
  logic [7:0]   req_addr = '0, req_bmask = '0;
  logic [1:0]   req_way = '0;
  logic [127:0] req_data = '0;
  logic         req_rdy, ld_stall_d, dcache_alt_addr_sel_e, dcache_wvld_e;
  logic         dcache_wclk_en_e, dcache_clk_en_e, dcw_empty;
  logic [7:0]   dcache_alt_addr_e;
  logic [143:0] dcache_wdata_e;
  logic [1:0]   dcache_wr_way_e;
  logic [15:0]  dcache_byte_wr_en_e;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  ent_t         q[$];
  int           blocked = 0;
  bit           exp_wvld = 0, exp_ldq = 0;
  logic [7:0]   exp_addr = '0;
  logic [1:0]   exp_way = '0;
  logic [143:0] exp_wdata = '0;
  logic [15:0]  exp_be = '0;
  int           stall_cycles[$];

  lsu_dcw_ctl #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .l2clk                 (l2clk),
    .lsu_rst               (lsu_rst),
    .req_vld               (req_vld),
    .req_rdy               (req_rdy),
    .req_fill              (req_fill),
    .req_addr              (req_addr),
    .req_way               (req_way),
    .req_data              (req_data),
    .req_bmask             (req_bmask),
    .ld_req_d              (ld_req_d),
    .ld_stall_d            (ld_stall_d),
    .dcache_alt_addr_e     (dcache_alt_addr_e),
    .dcache_alt_addr_sel_e (dcache_alt_addr_sel_e),
    .dcache_wvld_e         (dcache_wvld_e),
    .dcache_wclk_en_e      (dcache_wclk_en_e),
    .dcache_clk_en_e       (dcache_clk_en_e),
    .dcache_wdata_e        (dcache_wdata_e),
    .dcache_wr_way_e       (dcache_wr_way_e),
    .dcache_byte_wr_en_e   (dcache_byte_wr_en_e),
    .dcw_empty             (dcw_empty)
  );

  always #5 l2clk = ~l2clk;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] ref_par(input logic [127:0] d);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = d[8*i +: 8];
      p[i] = ($countones(b) % 2) == 1;
    end
    return p;
  endfunction

  function automatic ent_t ref_fmt(input bit fill, input logic [7:0] a, input logic [1:0] w,
                                   input logic [127:0] d, input logic [7:0] bm);
    ent_t e;
    e.way = w;
    if (fill) begin
      e.addr = a & 8'hFE;
      e.data = d;
      e.be   = 16'hFFFF;
    end else begin
      e.addr = a;
      e.data = {d[63:0], d[63:0]};
      e.be   = a[0] ? (16'(bm) << 8) : 16'(bm);
    end
    return e;
  endfunction

  task automatic step(input bit rst, input bit vld, input bit fill, input logic [7:0] a,
                      input logic [1:0] w, input logic [127:0] d, input logic [7:0] bm, input bit ld);
    ent_t e;
    bit head, forced, pop, push;
    @(negedge l2clk);
    lsu_rst = rst; req_vld = vld; req_fill = fill; req_addr = a;
    req_way = w; req_data = d; req_bmask = bm; ld_req_d = ld;
    #1;
    head   = q.size() != 0;
    forced = head && ld && blocked >= STARVE_MAX;
    pop    = head && (!ld || forced);
    push   = vld && q.size() < DEPTH;
    if (!rst) begin
      chk("ld_stall_d", ld_stall_d, forced);
      chk("req_rdy", req_rdy, q.size() < DEPTH);
      chk("dcw_empty", dcw_empty, q.size() == 0 && !exp_wvld);
      chk("clk_en_e", dcache_clk_en_e, exp_wvld || exp_ldq);
    end
    if (ld_stall_d === 1'b1) stall_cycles.push_back(cyc);
    @(posedge l2clk);
    #1;
    cyc++;
    if (rst) begin
      q.delete();
      blocked = 0; exp_wvld = 0; exp_ldq = 0;
      exp_addr = '0; exp_way = '0; exp_wdata = '0; exp_be = '0;
    end else begin
      if (pop) begin
        e = q.pop_front();
        exp_addr = e.addr; exp_way = e.way; exp_be = e.be;
        exp_wdata = {ref_par(e.data), e.data};
      end
      exp_wvld = pop;
      if (pop || !head) blocked = 0;
      else if (ld && blocked < STARVE_MAX) blocked++;
      exp_ldq = ld && !forced;
      if (push) q.push_back(ref_fmt(fill, a, w, d, bm));
    end
    chk("wvld_e", dcache_wvld_e, exp_wvld);
    chk("alt_sel_e", dcache_alt_addr_sel_e, exp_wvld);
    chk("wclk_en_e", dcache_wclk_en_e, exp_wvld);
    chk("alt_addr_e", dcache_alt_addr_e, exp_addr);
    chk("wr_way_e", dcache_wr_way_e, exp_way);
    chk("wdata_e", dcache_wdata_e, exp_wdata);
    chk("byte_wr_en_e", dcache_byte_wr_en_e, exp_be);
  endtask

  task automatic idle(input bit ld);
    step(0, 0, 0, 8'h00, 2'd0, 128'h0, 8'h00, ld);
  endtask

  initial begin
    logic [127:0] fill_d;
    int t0;
    fill_d = 128'h0102030405060708090a0b0c0d0e0f10;

    // reset and idle
    step(1, 0, 0, 8'h00, 2'd0, 128'h0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 2'd0, 128'h0, 8'h00, 0);
    idle(0);
    chk("reset_rdy", req_rdy, 1'b1);
    chk("reset_empty", dcw_empty, 1'b1);
    chk("reset_stall", ld_stall_d, 1'b0);

    // single fill
    step(0, 1, 1, 8'h25, 2'd2, fill_d, 8'h00, 0);
    idle(0);
    chk("fill_wvld", dcache_wvld_e, 1'b1);
    chk("fill_addr", dcache_alt_addr_e, 8'h24);
    chk("fill_be", dcache_byte_wr_en_e, 16'hFFFF);
    chk("fill_way", dcache_wr_way_e, 2'd2);
    chk("fill_par_01", dcache_wdata_e[143], 1'b1);
    chk("fill_par_03", dcache_wdata_e[141], 1'b0);
    idle(0);

    // single store to upper doubleword
    step(0, 1, 0, 8'h09, 2'd1, 128'hA5, 8'h0F, 0);
    idle(0);
    chk("store_be", dcache_byte_wr_en_e, 16'h0F00);
    chk("store_hi", dcache_wdata_e[127:64], 64'hA5);
    chk("store_lo", dcache_wdata_e[63:0], 64'hA5);
    idle(0);

    // starvation under continuous loads
    stall_cycles.delete();
    t0 = cyc;
    for (int i = 0; i < 4; i++)
      step(0, 1, i[0], 8'(8'h10 + i), 2'(i), {4{$urandom}}, 8'($urandom), 1);
    chk("full_rdy", req_rdy, 1'b0);
    for (int i = 0; i < 40; i++) idle(1);
    chk("stall_pulses", stall_cycles.size(), 4);
    if (stall_cycles.size() == 4) begin
      chk("first_force", stall_cycles[0] - t0, 9);
      for (int i = 1; i < 4; i++)
        chk("force_period", stall_cycles[i] - stall_cycles[i-1], 9);
    end

    // fill then store to the same index, back to back
    step(0, 1, 1, 8'h40, 2'd3, {4{$urandom}}, 8'h00, 0);
    step(0, 1, 0, 8'h41, 2'd3, {4{$urandom}}, 8'hFF, 0);
    chk("order_fill_be", dcache_byte_wr_en_e, 16'hFFFF);
    idle(0);
    chk("order_store_be", dcache_byte_wr_en_e, 16'hFF00);
    chk("order_store_wvld", dcache_wvld_e, 1'b1);
    idle(0);

    // reset with three queued entries and a write in e-stage
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 8'(8'h60 + i), 2'd0, {4{$urandom}}, 8'hFF, 1);
    idle(0);
    chk("pre_rst_wvld", dcache_wvld_e, 1'b1);
    step(1, 0, 0, 8'h00, 2'd0, 128'h0, 8'h00, 0);
    chk("rst_wvld", dcache_wvld_e, 1'b0);
    chk("rst_empty", dcw_empty, 1'b1);
    for (int i = 0; i < 5; i++) idle(0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit ld;
      ld = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
      step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom),
           2'($urandom), {$urandom, $urandom, $urandom, $urandom}, 8'($urandom), ld);
    end
    for (int i = 0; i < 10; i++) idle(0);
    chk("final_empty", dcw_empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
